// File: rtl/rram_access_ctrl_pkg.sv
// Shared definitions for the RRAM access controller: FSM state encoding and
// default geometry/timing constants.
package rram_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam int unsigned DEF_Y       = 5;
  localparam int unsigned DEF_DW      = 8;
  localparam int unsigned DEF_T_SETUP = 2;
  localparam int unsigned DEF_T_WRITE = 10;
  localparam int unsigned DEF_T_READ  = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rram_access_ctrl_pulse_timer.sv
// Loadable down-counter shared by the SETUP and PULSE phases; done while the count is zero.
module rram_pulse_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/rram_access_ctrl.sv
// Single-operation RRAM read/write sequencer: request handshake, timed wordline/bitline/
// sense-amp control, response handshake. Every output is a flop.
module rram_access_ctrl
  import rram_access_ctrl_pkg::*;
#(
  parameter int unsigned Y       = DEF_Y,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_WRITE = DEF_T_WRITE,
  parameter int unsigned T_READ  = DEF_T_READ
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [Y-1:0]  req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [Y-1:0]  dec_binary_in,
  output logic          dec_enable,
  output logic [DW-1:0] bl_wdata,
  output logic          bl_write_en,
  output logic          sa_enable,
  input  logic [DW-1:0] sa_data,
  output logic          busy
);

  localparam int unsigned T_MAX = max3(T_SETUP, T_WRITE, T_READ);
  localparam int unsigned CW    = $clog2(T_MAX + 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_WRITE = CW'(T_WRITE - 1);
  localparam logic [CW-1:0] LD_READ  = CW'(T_READ - 1);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [Y-1:0]  addr_q, addr_d;
  logic [DW-1:0] bl_wdata_q, bl_wdata_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          dec_en_q, dec_en_d;
  logic          bl_we_q, bl_we_d;
  logic          sa_en_q, sa_en_d;
  logic          busy_q, busy_d;
  logic          tmr_load, tmr_done, accept, capture;
  logic [CW-1:0] tmr_val;

  rram_pulse_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (req_valid) begin
        accept   = 1'b1;
        state_d  = ST_SETUP;
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
      end
      ST_SETUP: if (tmr_done) begin
        state_d  = ST_PULSE;
        tmr_load = 1'b1;
        tmr_val  = we_q ? LD_WRITE : LD_READ;
      end
      ST_PULSE: if (tmr_done) begin
        state_d = ST_HOLD;
        capture = !we_q;
      end
      ST_HOLD: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Address only ever moves on accept, so it is frozen while the wordline is enabled.
    we_d        = accept ? req_we    : we_q;
    wdata_d     = accept ? req_wdata : wdata_q;
    addr_d      = accept ? req_addr  : addr_q;
    rdata_d     = accept ? '0 : (capture ? sa_data : rdata_q);
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    dec_en_d    = (state_d == ST_PULSE);
    bl_we_d     = (state_d == ST_PULSE) && we_q;
    sa_en_d     = (state_d == ST_PULSE) && !we_q;
    bl_wdata_d  = bl_we_d ? wdata_q : '0;
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      addr_q      <= '0;
      bl_wdata_q  <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      dec_en_q    <= 1'b0;
      bl_we_q     <= 1'b0;
      sa_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      bl_wdata_q  <= bl_wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      dec_en_q    <= dec_en_d;
      bl_we_q     <= bl_we_d;
      sa_en_q     <= sa_en_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign dec_binary_in = addr_q;
  assign dec_enable    = dec_en_q;
  assign bl_wdata      = bl_wdata_q;
  assign bl_write_en   = bl_we_q;
  assign sa_enable     = sa_en_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rram_access_ctrl.sv
// Scoreboard bench for rram_access_ctrl: expected responses queued at accept, checked at
// response handshake; wordline/bitline/sense-amp behaviour monitored every cycle.
module tb_rram_access_ctrl;

  localparam int Y = 5, DW = 8, T_SETUP = 2, T_WRITE = 10, T_READ = 4;
  localparam int LAT_WR = 13, LAT_RD = 7;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [Y-1:0]  req_addr = '0;
  logic [DW-1:0] req_wdata = '0, sa_data = '0;
  logic          req_ready, rsp_valid, dec_enable, bl_write_en, sa_enable, busy;
  logic [DW-1:0] rsp_rdata, bl_wdata;
  logic [Y-1:0]  dec_binary_in;

  typedef struct {
    logic          we;
    logic [Y-1:0]  addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            accept_edge;
  } exp_t;

  exp_t          sb[$];
  int            total = 0, bad = 0, cyc = 0;
  int            en_cnt = 0, wr_cnt = 0, sa_cnt = 0, resp_cnt = 0, accept_cnt = 0;
  int            last_hs_edge = 0, last_accept_edge = 0, exp_len;
  logic          prev_en = 1'b0, prev_rsp = 1'b0;
  logic [Y-1:0]  prev_addr = '0;
  logic [DW-1:0] prev_rdata = '0, tb_sa = '0;

  rram_access_ctrl #(.Y(Y), .DW(DW), .T_SETUP(T_SETUP), .T_WRITE(T_WRITE), .T_READ(T_READ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .dec_binary_in(dec_binary_in), .dec_enable(dec_enable),
    .bl_wdata(bl_wdata), .bl_write_en(bl_write_en), .sa_enable(sa_enable), .sa_data(sa_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle monitor + sense-amp model: sa_data carries the true value only in the last read cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      en_cnt = 0; wr_cnt = 0; sa_cnt = 0;
      prev_en = 1'b0; prev_rsp = 1'b0; sa_data = '0;
    end else begin
      if (dec_enable || prev_en) begin
        total++;
        if (dec_binary_in !== prev_addr) begin
          bad++; $display("FAIL addr_glitch: dec_binary_in=%0d previous=%0d", dec_binary_in, prev_addr);
        end
      end
      total++;
      if (bl_write_en && sa_enable) begin
        bad++; $display("FAIL wr_sa_overlap: bl_write_en=1 sa_enable=1 at cycle %0d", cyc);
      end
      if (sb.size() > 0) begin
        if (dec_enable) begin
          en_cnt++; total++;
          if (dec_binary_in !== sb[0].addr) begin
            bad++; $display("FAIL dec_addr: got %0d want %0d", dec_binary_in, sb[0].addr);
          end
        end
        if (bl_write_en) begin
          wr_cnt++; total++;
          if (bl_wdata !== sb[0].wdata) begin
            bad++; $display("FAIL bl_wdata: got %h want %h", bl_wdata, sb[0].wdata);
          end
        end
        if (sa_enable) sa_cnt++;
        sa_data = (sa_enable && sa_cnt == T_READ) ? sb[0].rdata : ~sb[0].rdata;
        if (rsp_valid) begin
          total++;
          if (!prev_rsp) begin
            exp_len = sb[0].we ? LAT_WR : LAT_RD;
            if (cyc - sb[0].accept_edge != exp_len) begin
              bad++; $display("FAIL latency: got %0d want %0d", cyc - sb[0].accept_edge, exp_len);
            end
          end else if (rsp_rdata !== prev_rdata) begin
            bad++; $display("FAIL rdata_hold: got %h want %h", rsp_rdata, prev_rdata);
          end
          total++;
          if (rsp_rdata !== sb[0].rdata) begin
            bad++; $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, sb[0].rdata);
          end
          if (rsp_ready) begin
            exp_len = sb[0].we ? T_WRITE : T_READ;
            total++;
            if (en_cnt != exp_len) begin
              bad++; $display("FAIL dec_en_len: got %0d want %0d", en_cnt, exp_len);
            end
            total++;
            if (wr_cnt != (sb[0].we ? T_WRITE : 0)) begin
              bad++; $display("FAIL bl_we_len: got %0d want %0d", wr_cnt, sb[0].we ? T_WRITE : 0);
            end
            total++;
            if (sa_cnt != (sb[0].we ? 0 : T_READ)) begin
              bad++; $display("FAIL sa_en_len: got %0d want %0d", sa_cnt, sb[0].we ? 0 : T_READ);
            end
            void'(sb.pop_front());
            en_cnt = 0; wr_cnt = 0; sa_cnt = 0;
            last_hs_edge = cyc + 1;
            resp_cnt++;
          end
        end
      end else begin
        sa_data = '0;
        if (rsp_valid) begin
          total++; bad++; $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding");
        end
      end
      if (req_valid && req_ready) begin
        total++;
        if (sb.size() != 0) begin
          bad++; $display("FAIL outstanding: got %0d ops in flight want 0", sb.size());
        end
        sb.push_back('{we: req_we, addr: req_addr, wdata: req_wdata,
                       rdata: (req_we ? '0 : tb_sa), accept_edge: cyc + 1});
        last_accept_edge = cyc + 1;
        accept_cnt++;
      end
      prev_en    = dec_enable;
      prev_addr  = dec_binary_in;
      prev_rsp   = rsp_valid && !rsp_ready;
      prev_rdata = rsp_rdata;
    end
  end

  task automatic wait_accept(input int n);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (accept_cnt > n) break;
    end
    total++;
    if (accept_cnt <= n) begin
      bad++; $display("FAIL accept_timeout: accepts=%0d want >%0d", accept_cnt, n);
    end
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (resp_cnt >= n) break;
    end
    total++;
    if (resp_cnt < n) begin
      bad++; $display("FAIL resp_timeout: responses=%0d want %0d", resp_cnt, n);
    end
  endtask

  task automatic issue(input logic we, input logic [Y-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] sa);
    tb_sa = sa; req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
  endtask

  task automatic do_op(input logic we, input logic [Y-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] sa);
    int acc0, rsp0;
    acc0 = accept_cnt; rsp0 = resp_cnt;
    @(posedge clk); #1;
    issue(we, addr, wdata, sa);
    wait_accept(acc0);
    req_valid = 1'b0;
    wait_resp(rsp0 + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready, busy, rsp_valid, dec_enable, bl_write_en, sa_enable} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 100000",
                      {req_ready, busy, rsp_valid, dec_enable, bl_write_en, sa_enable});
    end
    total++;
    if ({rsp_rdata, bl_wdata, dec_binary_in} !== '0) begin
      bad++; $display("FAIL reset_data: rdata=%h wdata=%h addr=%0d want 0",
                      rsp_rdata, bl_wdata, dec_binary_in);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    rsp_ready = 1'b1;
    do_op(1'b1, 5'd5, 8'hA5, 8'h00);
    do_op(1'b1, 5'd0, 8'h5A, 8'h00);
  endtask

  task automatic test_read();
    rsp_ready = 1'b1;
    do_op(1'b0, 5'd31, 8'h00, 8'h3C);
    do_op(1'b0, 5'd0, 8'hFF, 8'hC1);
  endtask

  task automatic test_backpressure();
    int acc0, rsp0;
    acc0 = accept_cnt; rsp0 = resp_cnt;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1'b0, 5'd17, 8'h00, 8'h5A);
    wait_accept(acc0);
    issue(1'b1, 5'd7, 8'h11, 8'h00);
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    repeat (5) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, req_ready, busy} !== 3'b101) begin
        bad++; $display("FAIL bp_ctrl: valid/ready/busy=%b want 101", {rsp_valid, req_ready, busy});
      end
      total++;
      if (rsp_rdata !== 8'h5A) begin
        bad++; $display("FAIL bp_rdata: got %h want 5a", rsp_rdata);
      end
      total++;
      if (accept_cnt != acc0 + 1) begin
        bad++; $display("FAIL bp_accept: got %0d accepts want %0d", accept_cnt, acc0 + 1);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept(acc0 + 1);
    req_valid = 1'b0;
    wait_resp(rsp0 + 2);
  endtask

  task automatic test_back_to_back();
    int acc0, rsp0;
    acc0 = accept_cnt; rsp0 = resp_cnt;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 5'd3, 8'h5C, 8'h00);
    wait_accept(acc0);
    issue(1'b0, 5'd9, 8'h00, 8'h96);
    wait_accept(acc0 + 1);
    req_valid = 1'b0;
    total++;
    if (resp_cnt != rsp0 + 1) begin
      bad++; $display("FAIL b2b_order: responses=%0d at second accept want %0d", resp_cnt, rsp0 + 1);
    end
    total++;
    if (last_accept_edge != last_hs_edge + 1) begin
      bad++; $display("FAIL b2b_gap: accept edge %0d want %0d", last_accept_edge, last_hs_edge + 1);
    end
    wait_resp(rsp0 + 2);
  endtask

  task automatic test_reset_mid();
    int acc0, rsp0, seen;
    acc0 = accept_cnt; rsp0 = resp_cnt; seen = 0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 5'd12, 8'hE7, 8'h00);
    wait_accept(acc0);
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dec_enable) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({dec_enable, bl_write_en, sa_enable, rsp_valid, busy, req_ready} !== 6'b000001) begin
      bad++; $display("FAIL mid_reset: en/we/sa/valid/busy/ready=%b want 000001",
                      {dec_enable, bl_write_en, sa_enable, rsp_valid, busy, req_ready});
    end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    total++;
    if (seen != 0 || resp_cnt != rsp0) begin
      bad++; $display("FAIL mid_reset_rsp: got %0d valid cycles want 0", seen);
    end
    do_op(1'b0, 5'd12, 8'h00, 8'h81);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
